median_bin_thresh: RTL and testbench
====================================

# median_bin_thresh

Downstream stage of the 7x7 median filter. Consumes the filtered pixel stream (`median_valid`, `median_out`, and center coordinates) and emits a binarized stream (0/255). The threshold is the mean of the previous frame, computed by an 8-cycle sequential divider that runs between frames. Output goes to the PGM capture/writer path in place of raw median pixels.

## Interface
Parameters:
- IMAGE_WIDTH, 320, pixels per row; must match the median stage.
- IMAGE_HEIGHT, 240, rows per frame.
- COORD_W, 16, width of the row/column coordinate ports.
- INIT_THRESH, 128, threshold after reset and for the first frame.
- SUM_W, 25, accumulator width; must satisfy 2^SUM_W > 255·W·H.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- median_valid  in  1  input pixel strobe.
- median_out  in  8  filtered pixel value.
- center_row  in  COORD_W  row of the input pixel.
- center_col  in  COORD_W  column of the input pixel.
- bin_valid  out  1  output pixel strobe.
- bin_out  out  8  0 or 255.
- bin_row  out  COORD_W  registered copy of center_row.
- bin_col  out  COORD_W  registered copy of center_col.
- thresh  out  8  current threshold.
- thresh_update  out  1  one-cycle pulse when thresh is rewritten.
- frame_overrun  out  1  sticky error flag; cleared only by reset.

## Operation
- Per pixel accepted (median_valid=1): bin_out = 255 if median_out > thresh (strict), else 0. Row and column are passed through.
- Accumulators: sum += median_out; cnt += 1. cnt is the number of accepted pixels, not W·H, so dropped pixels do not bias the mean.
- End of frame (EOF): an accepted pixel with center_row==IMAGE_HEIGHT-1 and center_col==IMAGE_WIDTH-1.
  - On EOF in IDLE, sum_snap/cnt_snap capture the totals including the EOF pixel.
  - The accumulators restart at 0 on the next pixel.
  - State goes to DIV with k=7.
- FSM IDLE -> DIV -> IDLE.
  - DIV runs restoring division, one quotient bit per cycle for k=7..0: if rem >= (cnt_snap<<k), then rem -= cnt_snap<<k and q[k]=1.
  - After k=0: thresh<=q, thresh_update<=1, state back to IDLE.
  - Result is floor(sum_snap/cnt_snap), always ≤255.
- Pixels arriving during DIV are binarized with the old thresh and accumulate into the new frame normally.
- EOF during DIV: snapshot dropped, frame_overrun<=1, divide in progress unaffected, accumulators still restart.
- Coordinates outside the image are binarized and counted but never treated as EOF.

## Timing
- Reset values: bin_valid=0, bin_out=0, bin_row=0, bin_col=0, thresh=INIT_THRESH, thresh_update=0, frame_overrun=0, state=IDLE, sum=cnt=0.
- Reset mid-divide aborts the divide; thresh returns to INIT_THRESH.
- Pixel latency is 1 cycle: input sampled at edge E, bin_* valid in the cycle after E. Back-to-back input is accepted every cycle with no backpressure.
- Divider: EOF sampled at E0; quotient bits resolved at E1..E8.
  - thresh written at E8; thresh_update high from E8 to E9.
  - Pixels sampled at E8 or earlier use the old threshold; pixels from E9 onward use the new one.
- EOF sampled at E1..E8 sets the overrun. EOF at E9 or later is accepted.

## Configuration
- MEAN_THRESH_EN defined: adaptive mean threshold as described above.
- MEAN_THRESH_EN undefined:
  - thresh is fixed at INIT_THRESH.
  - No accumulators, divider or FSM are built.
  - thresh_update and frame_overrun are tied to 0.

## Test plan
Directed tests, with IMAGE_WIDTH=8 and IMAGE_HEIGHT=4 unless stated:
- Reset, then one pixel 129 followed by one pixel 128 → bin_out 255 then 0, each 1 cycle after its input, with row/col echoed.
- Frame of constant 100 → thresh_update at E8 after EOF and thresh=100. Next frame alternating 100/101 → 0/255.
- Frame of 31 pixels of 0 and one of 255 at EOF → thresh = floor(255/32) = 7. Frame of 16×10 and 16×21 → thresh = 15.
- Pixel 200 accepted at E8 and another 200 at E9, old thresh=255, new thresh=150 → outputs 0 then 255.
- WIDTH=4, HEIGHT=2, continuous 8-pixel frames → second EOF lands at E8 → frame_overrun=1, first divide still completes, flag persists until rst_n.
- Assert rst_n low at E4 of a divide → thresh=INIT_THRESH, no thresh_update, next frame divides correctly.
- MEAN_THRESH_EN undefined → thresh stays 128 across frames, thresh_update stays 0.

Source files
------------

// File: rtl/median_bin_thresh.sv
// Binarizes the median-filtered pixel stream against a threshold (0/255).
// Define MEAN_THRESH_EN to track the previous frame's mean; otherwise thresh is fixed at INIT_THRESH.
module median_bin_thresh #(
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240,
  parameter int unsigned COORD_W      = 16,
  parameter int unsigned INIT_THRESH  = 128,
  parameter int unsigned SUM_W        = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               median_valid,
  input  logic [7:0]         median_out,
  input  logic [COORD_W-1:0] center_row,
  input  logic [COORD_W-1:0] center_col,
  output logic               bin_valid,
  output logic [7:0]         bin_out,
  output logic [COORD_W-1:0] bin_row,
  output logic [COORD_W-1:0] bin_col,
  output logic [7:0]         thresh,
  output logic               thresh_update,
  output logic               frame_overrun
);

  localparam int unsigned MAX_SUM = 255 * IMAGE_WIDTH * IMAGE_HEIGHT;

  // Accumulator must hold a full frame of saturated pixels.
  if ($clog2(MAX_SUM + 1) > SUM_W) begin : g_sum_w_check
    $error("median_bin_thresh: SUM_W too narrow for IMAGE_WIDTH*IMAGE_HEIGHT");
  end

  logic [7:0] thresh_cur;

  // Pixel path: one-cycle compare and coordinate pass-through.
  logic               bin_valid_q, bin_valid_d;
  logic [7:0]         bin_out_q, bin_out_d;
  logic [COORD_W-1:0] bin_row_q, bin_row_d;
  logic [COORD_W-1:0] bin_col_q, bin_col_d;

  always_comb begin
    bin_valid_d = median_valid;
    bin_out_d   = bin_out_q;
    bin_row_d   = bin_row_q;
    bin_col_d   = bin_col_q;
    if (median_valid) begin
      bin_out_d = (median_out > thresh_cur) ? 8'd255 : 8'd0;
      bin_row_d = center_row;
      bin_col_d = center_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_valid_q <= 1'b0;
      bin_out_q   <= 8'd0;
      bin_row_q   <= '0;
      bin_col_q   <= '0;
    end else begin
      bin_valid_q <= bin_valid_d;
      bin_out_q   <= bin_out_d;
      bin_row_q   <= bin_row_d;
      bin_col_q   <= bin_col_d;
    end
  end

  assign bin_valid = bin_valid_q;
  assign bin_out   = bin_out_q;
  assign bin_row   = bin_row_q;
  assign bin_col   = bin_col_q;
  assign thresh    = thresh_cur;

`ifdef MEAN_THRESH_EN
  localparam int unsigned NPIX  = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned CNT_W = $clog2(NPIX + 1);
  localparam int unsigned DIV_W = SUM_W + 8;

  typedef enum logic {S_IDLE, S_DIV} state_e;

  state_e             state_q, state_d;
  logic [SUM_W-1:0]   sum_q, sum_d, rem_q, rem_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, div_cnt_q, div_cnt_d;
  logic [7:0]         quot_q, quot_d, thresh_q, thresh_d;
  logic [2:0]         k_q, k_d;
  logic               thresh_update_q, thresh_update_d;
  logic               frame_overrun_q, frame_overrun_d;
  logic               eof_c;
  logic [SUM_W-1:0]   sum_tot_c;
  logic [CNT_W-1:0]   cnt_tot_c;
  logic [DIV_W-1:0]   rem_ext_c, divisor_c;
  logic [7:0]         quot_bit_c;

  assign eof_c = median_valid
              && (center_row == COORD_W'(IMAGE_HEIGHT - 1))
              && (center_col == COORD_W'(IMAGE_WIDTH - 1));
  assign sum_tot_c = sum_q + SUM_W'(median_out);
  assign cnt_tot_c = cnt_q + CNT_W'(1);

  // Totals include the EOF pixel; the next frame starts from zero.
  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (median_valid) begin
      sum_d = eof_c ? '0 : sum_tot_c;
      cnt_d = eof_c ? '0 : cnt_tot_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (eof_c) state_d = S_DIV;
      S_DIV:   if (k_q == 3'd0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Restoring division, one quotient bit per cycle from k=7 down to 0.
  assign rem_ext_c  = DIV_W'(rem_q);
  assign divisor_c  = DIV_W'(div_cnt_q) << k_q;
  assign quot_bit_c = 8'(8'd1 << k_q);

  always_comb begin
    rem_d           = rem_q;
    quot_d          = quot_q;
    k_d             = k_q;
    div_cnt_d       = div_cnt_q;
    thresh_d        = thresh_q;
    thresh_update_d = 1'b0;
    frame_overrun_d = frame_overrun_q;
    case (state_q)
      S_IDLE: begin
        if (eof_c) begin
          rem_d     = sum_tot_c;
          div_cnt_d = cnt_tot_c;
          quot_d    = 8'd0;
          k_d       = 3'd7;
        end
      end
      S_DIV: begin
        if (eof_c) frame_overrun_d = 1'b1;
        if (rem_ext_c >= divisor_c) begin
          rem_d  = SUM_W'(rem_ext_c - divisor_c);
          quot_d = quot_q | quot_bit_c;
        end
        k_d = k_q - 3'd1;
        if (k_q == 3'd0) begin
          thresh_d        = quot_d;
          thresh_update_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q           <= '0;
      cnt_q           <= '0;
      rem_q           <= '0;
      div_cnt_q       <= '0;
      quot_q          <= 8'd0;
      k_q             <= 3'd0;
      thresh_q        <= 8'(INIT_THRESH);
      thresh_update_q <= 1'b0;
      frame_overrun_q <= 1'b0;
    end else begin
      sum_q           <= sum_d;
      cnt_q           <= cnt_d;
      rem_q           <= rem_d;
      div_cnt_q       <= div_cnt_d;
      quot_q          <= quot_d;
      k_q             <= k_d;
      thresh_q        <= thresh_d;
      thresh_update_q <= thresh_update_d;
      frame_overrun_q <= frame_overrun_d;
    end
  end

  assign thresh_cur    = thresh_q;
  assign thresh_update = thresh_update_q;
  assign frame_overrun = frame_overrun_q;
`else
  assign thresh_cur    = 8'(INIT_THRESH);
  assign thresh_update = 1'b0;
  assign frame_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_median_bin_thresh.sv
// Directed bench for median_bin_thresh on an 8x4 image; covers both MEAN_THRESH_EN builds.
module tb_median_bin_thresh;
  localparam int unsigned W = 8, H = 4, CW = 16, NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          median_valid;
  logic [7:0]    median_out;
  logic [CW-1:0] center_row, center_col;
  logic          bin_valid;
  logic [7:0]    bin_out;
  logic [CW-1:0] bin_row, bin_col;
  logic [7:0]    thresh;
  logic          thresh_update, frame_overrun;

  int   n_pass = 0;
  int   n_total = 0;
  bit   seen_upd = 1'b0;
  logic [7:0] frame_px [NPIX];

  median_bin_thresh #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .COORD_W(CW), .INIT_THRESH(128), .SUM_W(25)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .median_valid(median_valid), .median_out(median_out),
    .center_row(center_row), .center_col(center_col),
    .bin_valid(bin_valid), .bin_out(bin_out), .bin_row(bin_row), .bin_col(bin_col),
    .thresh(thresh), .thresh_update(thresh_update), .frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (thresh_update) seen_upd = 1'b1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [7:0] p, input int r, input int c);
    median_valid = v;
    median_out   = p;
    center_row   = CW'(r);
    center_col   = CW'(c);
  endtask

  task automatic idle();
    drive(1'b0, 8'd0, 0, 0);
  endtask

  task automatic wait_n(input int n);
    repeat (n) begin
      @(negedge clk);
      idle();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] b, input int split);
    for (int i = 0; i < NPIX; i++) frame_px[i] = (i < split) ? a : b;
  endtask

  // Raster-order frame; the last pixel is EOF and is sampled at the following posedge.
  task automatic send_frame(input bit chk_en, input logic [7:0] thr);
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      if (chk_en && i > 0)
        chk($sformatf("px%0d", i - 1), bin_out, (frame_px[i-1] > thr) ? 255 : 0);
      drive(1'b1, frame_px[i], i / W, i % W);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    chk("rst_bin_valid", bin_valid, 0);
    chk("rst_bin_out", bin_out, 0);
    chk("rst_bin_row", bin_row, 0);
    chk("rst_bin_col", bin_col, 0);
    chk("rst_thresh", thresh, 128);
    chk("rst_update", thresh_update, 0);
    chk("rst_overrun", frame_overrun, 0);
    rst_n = 1'b1;

    @(negedge clk); drive(1'b1, 8'd129, 1, 2);
    @(negedge clk);
    chk("p129_valid", bin_valid, 1);
    chk("p129_out", bin_out, 255);
    chk("p129_row", bin_row, 1);
    chk("p129_col", bin_col, 2);
    drive(1'b1, 8'd128, 0, 3);
    @(negedge clk);
    chk("p128_valid", bin_valid, 1);
    chk("p128_out", bin_out, 0);
    chk("p128_row", bin_row, 0);
    chk("p128_col", bin_col, 3);
    idle();
    @(negedge clk);
    chk("idle_valid", bin_valid, 0);

`ifdef MEAN_THRESH_EN
    do_reset();
    fill(8'd100, 8'd100, NPIX);
    send_frame(1'b0, 8'd128);
    wait_n(8);
    chk("c100_e7_update", thresh_update, 0);
    chk("c100_e7_thresh", thresh, 128);
    wait_n(1);
    chk("c100_e8_update", thresh_update, 1);
    chk("c100_e8_thresh", thresh, 100);
    wait_n(1);
    chk("c100_e9_update", thresh_update, 0);

    for (int i = 0; i < NPIX; i++) frame_px[i] = (i % 2 == 1) ? 8'd101 : 8'd100;
    send_frame(1'b1, 8'd100);
    wait_n(1);
    chk("alt_px31", bin_out, 255);
    wait_n(9);
    chk("alt_thresh", thresh, 100);

    fill(8'd0, 8'd255, 31);
    send_frame(1'b0, 8'd100);
    wait_n(9);
    chk("z255_update", thresh_update, 1);
    chk("z255_thresh", thresh, 7);
    wait_n(1);

    fill(8'd10, 8'd21, 16);
    send_frame(1'b0, 8'd7);
    wait_n(9);
    chk("m1021_thresh", thresh, 15);
    wait_n(1);

    fill(8'd255, 8'd255, NPIX);
    send_frame(1'b0, 8'd15);
    wait_n(10);
    chk("c255_thresh", thresh, 255);

    fill(8'd150, 8'd150, NPIX);
    send_frame(1'b0, 8'd255);
    wait_n(8);
    drive(1'b1, 8'd200, 0, 0);
    @(negedge clk);
    chk("edge_e8_out", bin_out, 0);
    chk("edge_e8_update", thresh_update, 1);
    chk("edge_e8_thresh", thresh, 150);
    drive(1'b1, 8'd200, 0, 1);
    @(negedge clk);
    chk("edge_e9_out", bin_out, 255);
    idle();

    do_reset();
    fill(8'd60, 8'd60, NPIX);
    send_frame(1'b0, 8'd128);
    wait_n(8);
    chk("ovr_pre", frame_overrun, 0);
    drive(1'b1, 8'd60, H - 1, W - 1);
    @(negedge clk);
    chk("ovr_set", frame_overrun, 1);
    chk("ovr_update", thresh_update, 1);
    chk("ovr_thresh", thresh, 60);
    idle();
    wait_n(10);
    chk("ovr_sticky", frame_overrun, 1);
    chk("ovr_no_second_div", thresh, 60);
    do_reset();
    chk("ovr_cleared", frame_overrun, 0);
    chk("ovr_rst_thresh", thresh, 128);

    fill(8'd40, 8'd40, NPIX);
    send_frame(1'b0, 8'd128);
    wait_n(5);
    rst_n = 1'b0;
    #1;
    chk("abort_thresh", thresh, 128);
    chk("abort_update", thresh_update, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_upd = 1'b0;
    wait_n(12);
    chk("abort_no_update", seen_upd, 0);
    chk("abort_thresh_hold", thresh, 128);

    fill(8'd90, 8'd90, NPIX);
    send_frame(1'b0, 8'd128);
    wait_n(9);
    chk("post_abort_update", thresh_update, 1);
    chk("post_abort_thresh", thresh, 90);
    drive(1'b1, 8'd250, H - 1, W - 1);
    wait_n(9);
    chk("eof_e9_update", thresh_update, 1);
    chk("eof_e9_thresh", thresh, 250);
    chk("eof_e9_overrun", frame_overrun, 0);
`else
    seen_upd = 1'b0;
    fill(8'd200, 8'd200, NPIX);
    send_frame(1'b1, 8'd128);
    wait_n(10);
    chk("fix_thresh_f1", thresh, 128);
    for (int i = 0; i < NPIX; i++) frame_px[i] = (i % 2 == 1) ? 8'd129 : 8'd128;
    send_frame(1'b1, 8'd128);
    wait_n(1);
    chk("fix_px31", bin_out, 255);
    wait_n(10);
    chk("fix_thresh_f2", thresh, 128);
    chk("fix_update_seen", seen_upd, 0);
    chk("fix_overrun", frame_overrun, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
